// File: rtl/pkt_axi_rd_master_pkg.sv
// pkt_axi_rd_master_pkg: shared AXI/AXIS types, constants and burst sizing helper
package pkt_axi_rd_master_pkg;
  typedef logic [15:0] udp_length_t;
  typedef logic [31:0] axi_addr_t;
  typedef logic [7:0] axi_alen_t;
  typedef logic [3:0] axi_id_t;
  localparam logic [1:0] AXI_OKAY = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  typedef enum logic [1:0] {RDM_IDLE_ST, RDM_AR_ST, RDM_RDATA_ST, RDM_DRAIN_ST} fsm_rdm_t;
  typedef struct packed {
    axi_id_t awid;
    axi_addr_t awaddr;
    axi_alen_t awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awvalid;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic wlast;
    logic wvalid;
    logic bready;
    axi_id_t arid;
    axi_addr_t araddr;
    axi_alen_t arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic arvalid;
    logic rready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic arready;
    logic rvalid;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic rlast;
  } s_axi_miso_t;
  typedef struct packed {
    logic tvalid;
    logic [7:0] tdata;
    logic tlast;
  } s_axis_mosi_t;
  typedef struct packed {
    logic tready;
  } s_axis_miso_t;
  function automatic logic [8:0] burst_beats(input udp_length_t rem, input int unsigned max_burst);
    logic [16:0] words;
    words = (17'(rem) + 17'd3) >> 2;
    return words > 17'(max_burst) ? 9'(max_burst) : words[8:0];
  endfunction
endpackage

// File: rtl/pkt_axi_rd_master_ser.sv
// pkt_word_ser: holds one 32-bit word and emits its low nbytes bytes LSB-first as an AXIS byte stream
// ports: load/word/nbytes/last_word fill the buffer, flush empties it, tvalid/tdata/tlast/tready form the byte handshake,
//        drained flags acceptance of the final buffered byte
module pkt_word_ser (
  input logic clk,
  input logic rst,
  input logic load,
  input logic flush,
  input logic [31:0] word,
  input logic [2:0] nbytes,
  input logic last_word,
  input logic tready,
  output logic tvalid,
  output logic [7:0] tdata,
  output logic tlast,
  output logic drained
);
  logic [31:0] buf_word;
  logic [2:0] buf_n;
  logic buf_last;
  logic [1:0] idx;
  logic at_end;
  assign at_end = {1'b0, idx} == buf_n - 3'd1;
  assign tdata = buf_word[{idx, 3'b000} +: 8];
  assign tlast = tvalid && at_end && buf_last;
  assign drained = tvalid && tready && at_end;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tvalid <= 1'b0;
      buf_word <= '0;
      buf_n <= '0;
      buf_last <= 1'b0;
      idx <= '0;
    end else if (flush) begin
      tvalid <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      buf_word <= word;
      buf_n <= nbytes;
      buf_last <= last_word;
      idx <= '0;
    end else if (tvalid && tready) begin
      idx <= idx + 2'd1;
      if (at_end) tvalid <= 1'b0;
    end
endmodule

// File: rtl/pkt_axi_rd_master.sv
// pkt_axi_rd_master: AXI4 read master fetching a packet via fixed-address 32-bit bursts onto an 8-bit AXIS stream
// ports: start_i/length_i/addr_i launch a packet, axi_mosi/axi_miso carry AR and R, axis_mosi/axis_miso carry bytes,
//        busy_o while active, done_o pulses on completion, error_o pulses when an aborted packet finishes
module pkt_axi_rd_master
  import pkt_axi_rd_master_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter axi_id_t AXI_ID = '0
) (
  input logic clk_axi,
  input logic rst_axi,
  input logic start_i,
  input udp_length_t length_i,
  input axi_addr_t addr_i,
  output s_axi_mosi_t axi_mosi,
  input s_axi_miso_t axi_miso,
  output s_axis_mosi_t axis_mosi,
  input s_axis_miso_t axis_miso,
  output logic busy_o,
  output logic done_o,
  output logic error_o
);
  fsm_rdm_t state, state_nx;
  udp_length_t rem_bytes, rem_after;
  axi_addr_t addr;
  logic [8:0] beat_cnt, beats;
  logic [2:0] buf_bytes;
  logic last_beat, done_q, error_q;
  logic arvalid, rready, acc_ar, acc_r, ok, load, flush, err_end;
  logic tvalid, tlast, drained;
  logic [7:0] tdata;
  assign beats = burst_beats(rem_bytes, MAX_BURST);
  assign acc_ar = arvalid && axi_miso.arready;
  assign acc_r = rready && axi_miso.rvalid;
  assign ok = axi_miso.rresp == AXI_OKAY;
  assign buf_bytes = rem_bytes >= 16'd4 ? 3'd4 : rem_bytes[2:0];
  assign rem_after = rem_bytes - 16'(buf_bytes);
  assign load = state == RDM_RDATA_ST && acc_r && ok;
  assign flush = state == RDM_DRAIN_ST && acc_r && axi_miso.rlast;
  assign err_end = flush || (state == RDM_RDATA_ST && acc_r && !ok && axi_miso.rlast);
  pkt_word_ser u_ser (
    .clk(clk_axi),
    .rst(rst_axi),
    .load(load),
    .flush(flush),
    .word(axi_miso.rdata),
    .nbytes(buf_bytes),
    .last_word(rem_after == '0),
    .tready(axis_miso.tready),
    .tvalid(tvalid),
    .tdata(tdata),
    .tlast(tlast),
    .drained(drained)
  );
  always_ff @(posedge clk_axi or posedge rst_axi)
    if (rst_axi) state <= RDM_IDLE_ST;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      RDM_IDLE_ST: state_nx = start_i && length_i != '0 ? RDM_AR_ST : RDM_IDLE_ST;
      RDM_AR_ST: state_nx = acc_ar ? RDM_RDATA_ST : RDM_AR_ST;
      RDM_RDATA_ST:
        if (acc_r && !ok) state_nx = axi_miso.rlast ? RDM_IDLE_ST : RDM_DRAIN_ST;
        else if (last_beat && (!tvalid || drained)) state_nx = rem_bytes == '0 ? RDM_IDLE_ST : RDM_AR_ST;
      RDM_DRAIN_ST: state_nx = flush ? RDM_IDLE_ST : RDM_DRAIN_ST;
      default: state_nx = RDM_IDLE_ST;
    endcase
  end
  // rready depends only on registers; last_beat stops further beats until the burst's final word drains
  always_comb begin
    arvalid = state == RDM_AR_ST;
    rready = state == RDM_DRAIN_ST || (state == RDM_RDATA_ST && !tvalid && !last_beat);
    busy_o = state != RDM_IDLE_ST;
    done_o = done_q || (state == RDM_IDLE_ST && start_i && length_i == '0);
    error_o = error_q;
    axis_mosi = '{tvalid: tvalid, tdata: tdata, tlast: tlast};
    axi_mosi = '0;
    axi_mosi.arvalid = arvalid;
    axi_mosi.rready = rready;
    if (arvalid) begin
      axi_mosi.arid = AXI_ID;
      axi_mosi.araddr = addr;
      axi_mosi.arlen = axi_alen_t'(beats - 9'd1);
      axi_mosi.arsize = AXI_SIZE_4B;
      axi_mosi.arburst = AXI_BURST_FIXED;
    end
  end
  always_ff @(posedge clk_axi or posedge rst_axi)
    if (rst_axi) begin
      rem_bytes <= '0;
      addr <= '0;
      beat_cnt <= '0;
      last_beat <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= tvalid && axis_miso.tready && tlast;
      error_q <= err_end;
      if (state == RDM_IDLE_ST && start_i) begin
        rem_bytes <= length_i;
        addr <= addr_i;
      end
      if (acc_ar) begin
        beat_cnt <= beats;
        last_beat <= 1'b0;
      end
      if (load) begin
        rem_bytes <= rem_after;
        beat_cnt <= beat_cnt - 9'd1;
        if (beat_cnt == 9'd1 || axi_miso.rlast) last_beat <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pkt_axi_rd_master.sv
// tb_pkt_axi_rd_master: table-driven and randomized check of the AXI read master against a byte-stream model
module tb_pkt_axi_rd_master;
  import pkt_axi_rd_master_pkg::*;
  localparam int MAXB = 16;
  typedef struct {
    int len;
    bit tmode;
    int early;
    int err_beat;
    bit err_last;
    bit poke;
    int nbytes;
    int nar;
    int done;
    int err;
  } vec_t;
  logic clk_axi = 1'b0;
  logic rst_axi = 1'b0;
  logic start_i = 1'b0;
  udp_length_t length_i = '0;
  axi_addr_t addr_i = '0;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;
  s_axis_mosi_t axis_mosi;
  s_axis_miso_t axis_miso;
  logic busy_o, done_o, error_o;
  int checks = 0, errors = 0;
  logic [31:0] sent[$];
  logic [7:0] got_b[$];
  logic got_l[$];
  int got_ar[$];
  int exp_ar[$];
  int cyc = 0, last_cyc, done_cyc, done_seen, err_seen;
  bit tmode, active, r_hs, first_burst, prev_stall;
  int early, err_beat, bi, blen, pkt_beat;
  bit err_last;
  logic [7:0] prev_data;
  logic prev_last;
  axi_addr_t cur_addr;
  vec_t vt[10];
  always #5 clk_axi = ~clk_axi;
  pkt_axi_rd_master #(.MAX_BURST(MAXB), .AXI_ID(4'd0)) dut (
    .clk_axi(clk_axi),
    .rst_axi(rst_axi),
    .start_i(start_i),
    .length_i(length_i),
    .addr_i(addr_i),
    .axi_mosi(axi_mosi),
    .axi_miso(axi_miso),
    .axis_mosi(axis_mosi),
    .axis_miso(axis_miso),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Expected AR lengths: each burst asks for min(MAXB, ceil(rem/4)) words; an early rlast shortens only the first burst
  function automatic void model_ars(input int len, input int early_at);
    int rem, b, got;
    bit first;
    rem = len;
    first = 1;
    exp_ar.delete();
    while (rem > 0) begin
      b = (rem + 3) / 4;
      if (b > MAXB) b = MAXB;
      exp_ar.push_back(b - 1);
      got = (first && early_at > 0 && early_at < b) ? early_at : b;
      rem = rem - got * 4;
      if (rem < 0) rem = 0;
      first = 0;
    end
  endfunction
  // AXI slave and AXIS sink; drives at the negedge and books handshakes that occur on the following posedge
  initial begin
    axi_miso = '0;
    axis_miso = '0;
    forever begin
      @(negedge clk_axi);
      cyc++;
      if (rst_axi) begin
        axi_miso = '0;
        axis_miso = '0;
        active = 0;
        r_hs = 0;
        prev_stall = 0;
        continue;
      end
      axis_miso.tready = tmode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        chk("stall_tvalid", axis_mosi.tvalid, 1);
        chk("stall_tdata", axis_mosi.tdata, prev_data);
        chk("stall_tlast", axis_mosi.tlast, prev_last);
      end
      if (axis_mosi.tvalid) chk("rready_while_buf", axi_mosi.rready, 0);
      if (axis_mosi.tvalid && axis_miso.tready) begin
        got_b.push_back(axis_mosi.tdata);
        got_l.push_back(axis_mosi.tlast);
        if (axis_mosi.tlast) last_cyc = cyc;
      end
      prev_stall = axis_mosi.tvalid && !axis_miso.tready;
      prev_data = axis_mosi.tdata;
      prev_last = axis_mosi.tlast;
      if (done_o) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (error_o) err_seen++;
      if (r_hs) begin
        axi_miso.rvalid = 0;
        axi_miso.rlast = 0;
        r_hs = 0;
      end
      if (active && !axi_miso.rvalid && (!tmode || $urandom_range(0, 1) == 1)) begin
        axi_miso.rvalid = 1;
        axi_miso.rdata = $urandom;
        axi_miso.rresp = pkt_beat == err_beat ? AXI_SLVERR : AXI_OKAY;
        axi_miso.rlast = bi == blen - 1 || (first_burst && early == bi + 1) || (pkt_beat == err_beat && err_last);
      end
      if (axi_miso.rvalid && axi_mosi.rready) begin
        r_hs = 1;
        if (axi_miso.rresp == AXI_OKAY) sent.push_back(axi_miso.rdata);
        bi++;
        pkt_beat++;
        if (axi_miso.rlast) begin
          active = 0;
          first_burst = 0;
        end
      end
      axi_miso.arready = !active && (!tmode || $urandom_range(0, 1) == 1);
      if (axi_mosi.arvalid && axi_miso.arready) begin
        got_ar.push_back(int'(axi_mosi.arlen));
        chk("arsize", axi_mosi.arsize, 2);
        chk("arburst", axi_mosi.arburst, AXI_BURST_FIXED);
        chk("araddr", axi_mosi.araddr, cur_addr);
        active = 1;
        bi = 0;
        blen = int'(axi_mosi.arlen) + 1;
      end
    end
  end
  task automatic setup(input vec_t v);
    sent.delete();
    got_b.delete();
    got_l.delete();
    got_ar.delete();
    done_seen = 0;
    err_seen = 0;
    last_cyc = -10;
    done_cyc = -20;
    tmode = v.tmode;
    early = v.early;
    err_beat = v.err_beat;
    err_last = v.err_last;
    first_burst = 1;
    pkt_beat = 0;
    cur_addr = $urandom;
  endtask
  task automatic run_pkt(input vec_t v);
    int nb, nar, nl;
    logic [31:0] w;
    setup(v);
    model_ars(v.len, v.early);
    nb = v.nbytes < 0 ? v.len : v.nbytes;
    nar = v.nar < 0 ? exp_ar.size() : v.nar;
    @(posedge clk_axi);
    #1 start_i = 1;
    length_i = 16'(v.len);
    addr_i = cur_addr;
    #1 if (v.len == 0) chk("done_same_cycle", done_o, 1);
    @(posedge clk_axi);
    #1 start_i = 0;
    length_i = 16'($urandom);
    addr_i = $urandom;
    chk("arvalid_latency", axi_mosi.arvalid, v.len != 0);
    chk("busy_after_start", busy_o, v.len != 0);
    if (v.poke) begin
      repeat (3) @(posedge clk_axi);
      #1 start_i = 1;
      length_i = 16'd5;
      @(posedge clk_axi);
      #1 start_i = 0;
    end
    for (int i = 0; i < 5000 && done_seen == 0 && err_seen == 0; i++) @(posedge clk_axi);
    repeat (4) @(posedge clk_axi);
    #1;
    chk("busy_end", busy_o, 0);
    chk("done_pulses", done_seen, v.done);
    chk("error_pulses", err_seen, v.err);
    chk("nbytes", got_b.size(), nb);
    chk("n_ar", got_ar.size(), nar);
    for (int i = 0; i < got_ar.size() && i < nar; i++) chk("arlen", got_ar[i], exp_ar[i]);
    for (int i = 0; i < got_b.size() && i < nb; i++) begin
      w = (i / 4 < sent.size()) ? sent[i / 4] : 32'h0;
      chk("byte", got_b[i], w[8 * (i % 4) +: 8]);
    end
    nl = 0;
    foreach (got_l[i]) if (got_l[i]) nl++;
    chk("tlast_count", nl, (v.err == 0 && nb > 0) ? 1 : 0);
    if (v.err == 0 && nb > 0 && got_l.size() == nb) chk("tlast_pos", got_l[nb - 1], 1);
    if (v.done != 0 && v.len > 0) chk("done_latency", done_cyc - last_cyc, 1);
  endtask
  initial begin
    vt[0] = '{8, 0, 0, -1, 0, 0, -1, -1, 1, 0};
    vt[1] = '{70, 0, 0, -1, 0, 0, -1, -1, 1, 0};
    vt[2] = '{0, 0, 0, -1, 0, 0, -1, -1, 1, 0};
    vt[3] = '{13, 1, 0, -1, 0, 0, -1, -1, 1, 0};
    vt[4] = '{16, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    vt[5] = '{4, 0, 0, -1, 0, 0, -1, -1, 1, 0};
    vt[6] = '{16, 1, 0, 1, 0, 0, 4, 1, 0, 1};
    vt[7] = '{40, 0, 3, -1, 0, 0, -1, -1, 1, 0};
    vt[8] = '{60, 0, 0, -1, 0, 1, -1, -1, 1, 0};
    vt[9] = '{3, 1, 0, -1, 0, 0, -1, -1, 1, 0};
    err_beat = -1;
    #2 rst_axi = 1;
    #1;
    chk("rst_axi_mosi_zero", axi_mosi == '0, 1);
    chk("rst_tvalid", axis_mosi.tvalid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    repeat (3) @(posedge clk_axi);
    #1 rst_axi = 0;
    foreach (vt[i]) run_pkt(vt[i]);
    setup('{16, 0, 0, -1, 0, 0, -1, -1, 1, 0});
    @(posedge clk_axi);
    #1 start_i = 1;
    length_i = 16'd16;
    addr_i = cur_addr;
    @(posedge clk_axi);
    #1 start_i = 0;
    for (int i = 0; i < 200 && sent.size() < 2; i++) @(posedge clk_axi);
    chk("beats_before_reset", sent.size(), 2);
    #2 rst_axi = 1;
    #1;
    chk("midrst_axi_mosi_zero", axi_mosi == '0, 1);
    chk("midrst_tvalid", axis_mosi.tvalid, 0);
    chk("midrst_tdata", axis_mosi.tdata, 0);
    chk("midrst_tlast", axis_mosi.tlast, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_error", error_o, 0);
    repeat (3) @(posedge clk_axi);
    #1 rst_axi = 0;
    @(posedge clk_axi);
    #1 chk("busy_after_rst", busy_o, 0);
    run_pkt(vt[0]);
    for (int k = 0; k < 8; k++) begin
      vec_t rv;
      rv = '{int'($urandom_range(1, 200)), 1'($urandom_range(0, 1)), 0, -1, 0, 0, -1, -1, 1, 0};
      run_pkt(rv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
